// File: rtl/axi_default_slave_burst.sv
// Default-route AXI slave: answers every read/write burst with an error response.
// Tracks up to DEPTH outstanding transactions per direction, IDs kept in order.
module axi_dsb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_multi
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + PTR_W'(1);
      end
      if (i_pop) begin
        r_rp <= r_rp + PTR_W'(1);
      end
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_multi = (r_cnt > CNT_W'(1));

endmodule

module axi_default_slave_burst #(
  parameter int          ID_W     = 8,
  parameter int          LEN_W    = 4,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 2,
  parameter logic [1:0]  ERR_RESP = 2'b11
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  input  logic [ID_W-1:0]   AWID,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              wlast_err
);

  localparam int Q_W = ID_W + LEN_W;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  // Holds the READYs low until the first clock after reset release
  logic r_live;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  logic w_unused;
  assign w_unused = ^WDATA;

  logic [Q_W-1:0]   w_rq_head;
  logic [ID_W-1:0]  w_rq_id;
  logic [LEN_W-1:0] w_rq_len;
  logic             w_rq_empty;
  logic             w_rq_full;
  logic             w_rq_multi;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_r_pop;
  logic             w_rvalid;
  logic             w_rlast;
  r_state_e         r_rstate;
  r_state_e         w_rstate_nx;
  logic [LEN_W-1:0] r_rcnt;

  assign ARREADY = r_live && !w_rq_full;
  assign w_ar_hs = ARVALID && ARREADY;

  axi_dsb_fifo #(
    .W     (Q_W),
    .DEPTH (DEPTH)
  ) u_rq (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_push  (w_ar_hs),
    .i_data  ({ARID, ARLEN}),
    .i_pop   (w_r_pop),
    .o_head  (w_rq_head),
    .o_empty (w_rq_empty),
    .o_full  (w_rq_full),
    .o_multi (w_rq_multi)
  );

  assign w_rq_id  = w_rq_head[Q_W-1 -: ID_W];
  assign w_rq_len = w_rq_head[LEN_W-1:0];

  assign w_rvalid = (r_rstate == R_BURST);
  assign w_rlast  = w_rvalid && (r_rcnt == w_rq_len);
  assign w_r_hs   = w_rvalid && RREADY;
  assign w_r_pop  = w_r_hs && w_rlast;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_nx;
    end
  end

  // Stay in R_BURST across bursts so queued reads stream without a bubble
  always_comb begin
    w_rstate_nx = r_rstate;
    unique case (r_rstate)
      R_IDLE: begin
        if (!w_rq_empty) begin
          w_rstate_nx = R_BURST;
        end
      end
      R_BURST: begin
        if (w_r_pop && !w_rq_multi) begin
          w_rstate_nx = R_IDLE;
        end
      end
      default: w_rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rcnt <= '0;
    end else if (!w_rvalid) begin
      r_rcnt <= '0;
    end else if (w_r_hs) begin
      r_rcnt <= w_rlast ? '0 : r_rcnt + LEN_W'(1);
    end
  end

  assign RVALID = w_rvalid;
  assign RLAST  = w_rlast;
  assign RID    = w_rvalid ? w_rq_id : '0;
  assign RRESP  = w_rvalid ? ERR_RESP : 2'b00;
  assign RDATA  = '0;

  logic [Q_W-1:0]   w_aq_head;
  logic [ID_W-1:0]  w_aq_id;
  logic [LEN_W-1:0] w_aq_len;
  logic             w_aq_empty;
  logic             w_aq_full;
  logic             w_aq_multi_unused;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_w_done;
  logic [ID_W-1:0]  w_bq_head;
  logic             w_bq_empty;
  logic             w_bq_full;
  logic             w_bq_multi_unused;
  logic             w_b_pop;
  logic [LEN_W-1:0] r_wcnt;
  logic             r_wover;
  logic             r_wlast_err;

  assign AWREADY = r_live && !w_aq_full;
  assign w_aw_hs = AWVALID && AWREADY;

  axi_dsb_fifo #(
    .W     (Q_W),
    .DEPTH (DEPTH)
  ) u_aq (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_push  (w_aw_hs),
    .i_data  ({AWID, AWLEN}),
    .i_pop   (w_w_done),
    .o_head  (w_aq_head),
    .o_empty (w_aq_empty),
    .o_full  (w_aq_full),
    .o_multi (w_aq_multi_unused)
  );

  assign w_aq_id  = w_aq_head[Q_W-1 -: ID_W];
  assign w_aq_len = w_aq_head[LEN_W-1:0];

  assign WREADY   = r_live && !w_aq_empty && !w_bq_full;
  assign w_w_hs   = WVALID && WREADY;
  assign w_w_done = w_w_hs && WLAST;

  // r_wover remembers beats past LEN so a late WLAST is still flagged
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wcnt      <= '0;
      r_wover     <= 1'b0;
      r_wlast_err <= 1'b0;
    end else begin
      r_wlast_err <= 1'b0;
      if (w_w_done) begin
        r_wcnt      <= '0;
        r_wover     <= 1'b0;
        r_wlast_err <= r_wover || (r_wcnt != w_aq_len);
      end else if (w_w_hs) begin
        if (r_wcnt == w_aq_len) begin
          r_wover <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + LEN_W'(1);
        end
      end
    end
  end

  assign wlast_err = r_wlast_err;

  axi_dsb_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_bq (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .i_push  (w_w_done),
    .i_data  (w_aq_id),
    .i_pop   (w_b_pop),
    .o_head  (w_bq_head),
    .o_empty (w_bq_empty),
    .o_full  (w_bq_full),
    .o_multi (w_bq_multi_unused)
  );

  assign BVALID  = !w_bq_empty;
  assign w_b_pop = BVALID && BREADY;
  assign BID     = BVALID ? w_bq_head : '0;
  assign BRESP   = BVALID ? ERR_RESP : 2'b00;

endmodule

// File: tb/tb_axi_default_slave_burst.sv
// Directed bench for axi_default_slave_burst: reads, bursts, writes,
// WLAST mismatch, queue back-pressure and mid-burst reset.
module tb_axi_default_slave_burst;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  ARID;
  logic [3:0]  ARLEN;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [7:0]  AWID;
  logic [3:0]  AWLEN;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        wlast_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axi_default_slave_burst dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ARID      (ARID),
    .ARLEN     (ARLEN),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RID       (RID),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RLAST     (RLAST),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .AWID      (AWID),
    .AWLEN     (AWLEN),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WLAST     (WLAST),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BID       (BID),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .wlast_err (wlast_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  logic [4:0] pat;
  logic [4:0] lst;
  int         beats;

  initial begin
    ARESETn = 1'b0;
    ARID = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    AWID = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = 32'hDEAD_BEEF; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0;
    #2;
    chk("rst_arready", ARREADY, 0);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bvalid", BVALID, 0);
    step(); step();
    ARESETn = 1'b1;
    step();
    chk("rel_arready", ARREADY, 1);
    chk("rel_awready", AWREADY, 1);

    // single read
    ARVALID = 1'b1; ARID = 8'h5A; ARLEN = 4'd0; RREADY = 1'b1;
    step();
    ARVALID = 1'b0;
    chk("t1_rvalid_n", RVALID, 0);
    step();
    chk("t1_rvalid", RVALID, 1);
    chk("t1_rid", RID, 32'h5A);
    chk("t1_rresp", RRESP, 3);
    chk("t1_rlast", RLAST, 1);
    chk("t1_rdata", RDATA, 0);
    step();
    chk("t1_rvalid_n2", RVALID, 0);

    // burst read with RREADY toggling
    ARVALID = 1'b1; ARID = 8'h77; ARLEN = 4'd3;
    step();
    ARVALID = 1'b0;
    step();
    pat = 5'b11101;
    lst = 5'b10000;
    beats = 0;
    for (int k = 0; k < 5; k++) begin
      RREADY = pat[k];
      chk($sformatf("t2_rvalid%0d", k), RVALID, 1);
      chk($sformatf("t2_rlast%0d", k), RLAST, 32'(lst[k]));
      chk($sformatf("t2_rid%0d", k), RID, 32'h77);
      chk($sformatf("t2_rresp%0d", k), RRESP, 3);
      if (RVALID && RREADY) beats++;
      step();
    end
    chk("t2_beats", beats, 4);
    chk("t2_rvalid_end", RVALID, 0);

    // two queued reads streamed back to back
    RREADY = 1'b0;
    ARVALID = 1'b1; ARID = 8'h01; ARLEN = 4'd1;
    step();
    ARID = 8'h02; ARLEN = 4'd0;
    step();
    ARVALID = 1'b0;
    chk("t3_arready_full", ARREADY, 0);
    RREADY = 1'b1;
    chk("t3_b0_v", RVALID, 1);
    chk("t3_b0_id", RID, 32'h01);
    chk("t3_b0_last", RLAST, 0);
    step();
    chk("t3_b1_v", RVALID, 1);
    chk("t3_b1_id", RID, 32'h01);
    chk("t3_b1_last", RLAST, 1);
    step();
    chk("t3_b2_v", RVALID, 1);
    chk("t3_b2_id", RID, 32'h02);
    chk("t3_b2_last", RLAST, 1);
    chk("t3_arready", ARREADY, 1);
    step();
    chk("t3_rvalid_end", RVALID, 0);
    RREADY = 1'b0;

    // well-formed write burst
    BREADY = 1'b1;
    AWVALID = 1'b1; AWID = 8'h33; AWLEN = 4'd2;
    chk("t4_awready", AWREADY, 1);
    chk("t4_wready_noaw", WREADY, 0);
    step();
    AWVALID = 1'b0;
    chk("t4_wready", WREADY, 1);
    WVALID = 1'b1; WLAST = 1'b0;
    step();
    chk("t4_err0", wlast_err, 0);
    step();
    chk("t4_err1", wlast_err, 0);
    WLAST = 1'b1;
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("t4_err2", wlast_err, 0);
    chk("t4_bvalid", BVALID, 1);
    chk("t4_bid", BID, 32'h33);
    chk("t4_bresp", BRESP, 3);
    chk("t4_wready_n", WREADY, 0);
    step();
    chk("t4_bvalid_n", BVALID, 0);
    chk("t4_err3", wlast_err, 0);

    // early WLAST and B queue back-pressure
    BREADY = 1'b0;
    AWVALID = 1'b1; AWID = 8'h44; AWLEN = 4'd3;
    step();
    AWID = 8'h55; AWLEN = 4'd0;
    WVALID = 1'b1; WLAST = 1'b0;
    step();
    AWVALID = 1'b0;
    chk("t5_awready_full", AWREADY, 0);
    WLAST = 1'b1;
    step();
    chk("t5_err", wlast_err, 1);
    chk("t5_bvalid", BVALID, 1);
    chk("t5_bid44", BID, 32'h44);
    chk("t5_wready", WREADY, 1);
    step();
    chk("t5_err_pulse", wlast_err, 0);
    WVALID = 1'b0; WLAST = 1'b0;
    AWVALID = 1'b1; AWID = 8'h66; AWLEN = 4'd0;
    chk("t5_awready3", AWREADY, 1);
    step();
    AWVALID = 1'b0;
    chk("t5_wready_bqfull", WREADY, 0);
    chk("t5_bid_hold", BID, 32'h44);
    BREADY = 1'b1;
    step();
    BREADY = 1'b0;
    chk("t5_bid55", BID, 32'h55);
    chk("t5_bvalid2", BVALID, 1);
    chk("t5_wready2", WREADY, 1);

    // reset in the middle of a read and a write burst
    ARVALID = 1'b1; ARID = 8'h99; ARLEN = 4'd3; RREADY = 1'b0;
    WVALID = 1'b1; WLAST = 1'b0;
    step();
    ARVALID = 1'b0; WVALID = 1'b0;
    step();
    chk("t6_rvalid_pre", RVALID, 1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("t6_rvalid_rst", RVALID, 0);
    chk("t6_bvalid_rst", BVALID, 0);
    chk("t6_arready_rst", ARREADY, 0);
    chk("t6_awready_rst", AWREADY, 0);
    chk("t6_wready_rst", WREADY, 0);
    RREADY = 1'b1; BREADY = 1'b1;
    step(); step();
    #3;
    ARESETn = 1'b1;
    step();
    chk("t6_arready", ARREADY, 1);
    chk("t6_awready", AWREADY, 1);
    chk("t6_wready", WREADY, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t6_rvalid%0d", k), RVALID, 0);
      chk($sformatf("t6_bvalid%0d", k), BVALID, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_default_slave_burst.md
Name: axi_default_slave_burst

Overview:
- Parametrised successor to the single-beat AXI default slave: terminates every AXI transaction that decodes to no mapped slave.
- Returns an error response on all beats and supports bursts (ARLEN/AWLEN).
- Queues up to DEPTH outstanding reads and writes, keeping per-transaction IDs in order.
- Sits behind the interconnect decoder as the default-route slave port.

Parameters:
- ID_W, 8, width of ARID/AWID/RID/BID
- LEN_W, 4, width of ARLEN/AWLEN (burst beats = LEN+1)
- DATA_W, 32, width of RDATA/WDATA
- DEPTH, 2, outstanding-transaction capacity per direction (power of 2, ≥2)
- ERR_RESP, 2'b11, response code driven on R and B (DECERR)

Ports:
- ACLK in 1 clock
- ARESETn in 1 asynchronous active-low reset
- ARID in ID_W read address ID
- ARLEN in LEN_W read burst length
- ARVALID in 1 / ARREADY out 1: AR handshake
- RID out ID_W read ID
- RDATA out DATA_W read data, always 0
- RRESP out 2 read response
- RLAST out 1 last read beat
- RVALID out 1 / RREADY in 1: R handshake
- AWID in ID_W write address ID
- AWLEN in LEN_W write burst length
- AWVALID in 1 / AWREADY out 1: AW handshake
- WDATA in DATA_W write data, ignored
- WLAST in 1 last write beat
- WVALID in 1 / WREADY out 1: W handshake
- BID out ID_W write response ID
- BRESP out 2 write response
- BVALID out 1 / BREADY in 1: B handshake
- wlast_err out 1 one-cycle pulse on WLAST/beat-count mismatch

Behaviour:
- Reset (ARESETn low, asynchronous): all queues empty, counters 0, all outputs 0, including the READYs. READYs are gated low while in reset.
- Read queue (RQ): DEPTH entries of {ID, LEN}.
  - ARREADY = !RQ_full. Full is evaluated before any same-cycle pop; no accept-on-pop when full.
- R engine: states R_IDLE and R_BURST; beat counter rcnt.
  - R_IDLE → R_BURST when RQ non-empty. Loads RID from the RQ head, clears rcnt, asserts RVALID on the next edge.
  - Minimum latency: AR handshake at cycle N gives first RVALID at N+1.
  - Each R handshake increments rcnt. RLAST = RVALID && (rcnt == head LEN).
  - On the RLAST handshake, pop RQ. If RQ is still non-empty, continue back-to-back with the next burst (RVALID stays high, no bubble); else go to R_IDLE.
  - RRESP = ERR_RESP when RVALID, else 2'b00. RDATA = 0 always.
  - RID/RLAST/RRESP hold stable while RVALID && !RREADY.
- Write address queue (AQ): DEPTH entries of {ID, LEN}. AWREADY = !AQ_full.
- W acceptance: WREADY = AQ non-empty && !BQ_full. W may not be accepted before its AW; same-cycle AW+first W is not required.
  - Beat counter wcnt counts W handshakes against the AQ head.
  - Burst completes on the W handshake with WLAST=1. On completion: pop AQ, push head ID into BQ, clear wcnt.
  - wlast_err pulses 1 cycle if wcnt != head LEN at the WLAST beat. Completion still occurs on WLAST.
  - If wcnt reaches head LEN without WLAST, further beats keep counting until WLAST arrives. wlast_err pulses at that WLAST.
- B queue (BQ): DEPTH entries of ID.
  - BVALID = BQ non-empty (registered: first BVALID one cycle after the WLAST handshake).
  - BID = BQ head. BRESP = ERR_RESP when BVALID, else 0.
  - Pop on BVALID && BREADY. Push and pop in the same cycle are legal.
- Read and write paths are fully independent and may be active simultaneously.
- Pointers wrap modulo DEPTH. A separate count register, width clog2(DEPTH)+1, distinguishes full from empty.
- Reset mid-burst: all state is discarded; no partial responses after reset release.

Test Plan:
- Single read, ARID=0x5A, ARLEN=0, RREADY=1 → RVALID at N+1 with RID=0x5A, RRESP=2'b11, RLAST=1, RDATA=0; RVALID=0 at N+2.
- Burst read, ARLEN=3, RREADY toggling 1,0,1,1,1 → exactly 4 beats; RLAST only on beat 4; outputs held during the RREADY=0 cycle.
- Two back-to-back ARs (IDs 0x01 LEN=1, 0x02 LEN=0) with DEPTH=2 → ARREADY=0 after both; R beats 0x01,0x01(last),0x02(last) with no gap.
- Write: AWID=0x33 AWLEN=2, three W beats with WLAST on the 3rd → one B with BID=0x33, BRESP=2'b11, wlast_err never asserted.
- WLAST on beat 2 of an AWLEN=3 burst → wlast_err pulse, B issued for that ID. With BREADY=0, a 3rd AW still accepted while WREADY=0 once BQ is full (2 entries).
- Assert ARESETn=0 mid-read-burst and mid-write → RVALID/BVALID/READYs 0 immediately; after release ARREADY=AWREADY=1 and no stale responses.
